// File: rtl/receiver.sv
// receiver: serial-to-parallel receive stage for the idle-high single-wire link.
// Frame: start(0), even parity, 7 data bits LSB first, stop(1); each bit is
// CLKS_PER_BIT clocks. The line is synchronised, each bit is sampled at its
// centre, and the word is presented with a one-cycle valid strobe plus flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | half a bit in, confirm start bit or reject as false start
// PARITY    | one bit later, capture parity bit
// DATA      | capture data bits 0..6 at bit centres
// STOP      | capture stop bit, publish word and error flags
// WAIT_IDLE | stop bit was low, hold until the line returns high
module receiver #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [6:0] data_out,
    output logic       out_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PARITY,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Counter terminal values: the start check lands half a bit after the
    // first low sample, every later sample exactly one bit after the previous.
    localparam logic [7:0] HALF_TC = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] BIT_TC  = 8'(CLKS_PER_BIT - 1);

    logic       rx_meta;
    logic       rx_s;
    state_t     state;
    logic [7:0] clk_count;
    logic [3:0] bit_idx;
    logic [6:0] shift_reg;
    logic       parity_bit;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with bit timer, data capture and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_count  <= 8'd0;
            bit_idx    <= 4'd0;
            shift_reg  <= 7'd0;
            parity_bit <= 1'b0;
            data_out   <= 7'd0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    clk_count <= 8'd0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (clk_count == HALF_TC) begin
                        clk_count <= 8'd0;
                        if (rx_s) begin
                            // Low pulse did not last to mid-bit: ignore it.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= PARITY;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end
                PARITY: begin
                    if (clk_count == BIT_TC) begin
                        clk_count  <= 8'd0;
                        parity_bit <= rx_s;
                        bit_idx    <= 4'd0;
                        state      <= DATA;
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end
                DATA: begin
                    if (clk_count == BIT_TC) begin
                        clk_count            <= 8'd0;
                        shift_reg[bit_idx[2:0]] <= rx_s;
                        if (bit_idx == 4'd6) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end
                STOP: begin
                    if (clk_count == BIT_TC) begin
                        clk_count  <= 8'd0;
                        out_valid  <= 1'b1;
                        data_out   <= shift_reg;
                        parity_err <= parity_bit ^ (^shift_reg);
                        frame_err  <= ~rx_s;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            // A low stop bit means break or stuck line; do not
                            // let the still-low line start a new frame.
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end
                WAIT_IDLE: begin
                    clk_count <= 8'd0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    clk_count <= 8'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: table-driven and randomized checks of the receiver against a
// frame-level reference model (expected word, flags and strobe cycle).
module tb_receiver;

    localparam int CPB = 4;
    localparam int H   = CPB / 2;
    localparam int LAT = 3 + H + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [6:0] data_out;
    logic       out_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int         cyc;
        logic [6:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       expq[$];
    exp_t       mon_e;
    logic [6:0] last_d = 7'd0;

    typedef struct {
        logic [6:0] d;
        logic       par;
        logic       stop;
        int         hold;
        logic [6:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic at_cyc(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    // All bit-level drives start just after a rising edge and end aligned.
    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] d, input logic par, input logic stop,
                              input bit expect_out);
        exp_t e;
        e.cyc = cyc + LAT;
        e.d   = d;
        e.pe  = (par != ^d);
        e.fe  = ~stop;
        if (expect_out) expq.push_back(e);
        send_bit(1'b0);
        send_bit(par);
        for (int k = 0; k < 7; k++) send_bit(d[k]);
        send_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Every strobe must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got out_valid=1 data_out=%0h expected no strobe (cycle %0d)",
                         data_out, cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("data_out", 32'(data_out), 32'(mon_e.d));
                chk("parity_err", 32'(parity_err), 32'(mon_e.pe));
                chk("frame_err", 32'(frame_err), 32'(mon_e.fe));
                chk("busy_at_valid", 32'(busy), 32'(mon_e.fe));
                last_d = mon_e.d;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int r;
        logic [6:0] d;
        logic       par;

        tbl[0] = '{d: 7'h55, par: 1'b0, stop: 1'b1, hold: 0, exp_d: 7'h55, exp_pe: 1'b0, exp_fe: 1'b0};
        tbl[1] = '{d: 7'h01, par: 1'b0, stop: 1'b1, hold: 0, exp_d: 7'h01, exp_pe: 1'b1, exp_fe: 1'b0};
        tbl[2] = '{d: 7'h7F, par: 1'b1, stop: 1'b0, hold: 3, exp_d: 7'h7F, exp_pe: 1'b0, exp_fe: 1'b1};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(4);

        // Table-driven frames: normal, parity error, frame error with held-low line.
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.cyc = cyc + LAT;
            e.d   = tbl[i].exp_d;
            e.pe  = tbl[i].exp_pe;
            e.fe  = tbl[i].exp_fe;
            expq.push_back(e);
            if (i == 0) begin
                t = cyc;
                fork
                    send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 1'b0);
                    begin
                        at_cyc(t + 2);
                        chk("busy_before_rise", 32'(busy), 32'd0);
                        at_cyc(t + 3);
                        chk("busy_rise", 32'(busy), 32'd1);
                    end
                join
            end else begin
                send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 1'b0);
            end
            if (tbl[i].hold > 0) begin
                rx = 1'b0;
                repeat (tbl[i].hold * CPB) @(posedge clk);
                #1;
                rx = 1'b1;
                r  = cyc;
                at_cyc(r + 2);
                chk("busy_wait_idle_held", 32'(busy), 32'd1);
                at_cyc(r + 3);
                chk("busy_wait_idle_drop", 32'(busy), 32'd0);
                @(posedge clk);
                #1;
            end
            idle_cycles(2 * CPB);
        end

        // One-cycle glitch on an idle line: no strobe, outputs held.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        idle_cycles(3 * CPB);
        chk("glitch_data_held", 32'(data_out), 32'(last_d));
        chk("glitch_busy", 32'(busy), 32'd0);
        send_frame(7'h2A, 1'b1, 1'b1, 1'b1);
        idle_cycles(2 * CPB);

        // Back-to-back frames with correct parity, no idle gap between them.
        send_frame(7'h12, ^7'h12, 1'b1, 1'b1);
        send_frame(7'h6D, ^7'h6D, 1'b1, 1'b1);
        send_frame(7'h00, ^7'h00, 1'b1, 1'b1);
        idle_cycles(2 * CPB);

        // Random frames, occasional parity corruption, random gaps (incl. zero).
        for (int n = 0; n < 20; n++) begin
            d   = 7'($urandom_range(0, 127));
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, par, 1'b1, 1'b1);
            if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 2 * CPB));
        end
        send_frame(7'h5A, ^7'h5A, 1'b1, 1'b1);
        idle_cycles(LAT);

        // Reset while bit 3 of the data field is being sampled.
        t = cyc;
        fork
            send_frame(7'h44, ^7'h44, 1'b1, 1'b0);
            begin
                at_cyc(t + 23);
                rst_n = 1'b0;
                #1;
                chk_all_zero("midframe_reset");
            end
        join
        idle_cycles(4);
        rst_n = 1'b1;
        idle_cycles(4);
        send_frame(7'h33, ^7'h33, 1'b1, 1'b1);
        idle_cycles(LAT + 10);

        chk("queue_empty", 32'(expq.size()), 32'd0);
        while (expq.size() > 0) begin
            mon_e = expq.pop_front();
            $display("FAIL missing_frame: got no strobe expected data %0h at cycle %0d", mon_e.d, mon_e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/receiver.md
# receiver

Serial-to-parallel receive stage consuming the single-wire stream produced by the `sender` block, or by a compatible remote transmitter. Frame order is idle-high line, start bit (0), even-parity bit, 7 data bits LSB first, then stop bit (1), with each bit lasting CLKS_PER_BIT clocks. The block synchronises the line, samples each bit at its centre, and checks parity and stop bit. It then presents the 7-bit word with a one-cycle valid strobe to the downstream consumer.

## Interface
- CLKS_PER_BIT, 87, clocks per serial bit; legal range 2..256; must match the transmitter.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; asynchronous to clk; idles high.
- data_out  output  7  last received word; bit 0 is the first data bit received.
- out_valid  output  1  one-cycle strobe: data_out, parity_err and frame_err are updated and valid.
- parity_err  output  1  received parity bit != XOR of the 7 received data bits.
- frame_err  output  1  stop bit sampled as 0.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- rx passes through a 2-flop synchroniser to give rx_s; rx_s(t) = rx(t-2). The FSM uses only rx_s.
- States:
  - IDLE: wait for start; rx_s == 0 moves to START with clk_count = 0.
  - START: check the start bit at mid-bit; rx_s == 1 means a false start and returns to IDLE with no output; rx_s == 0 moves to PARITY.
  - PARITY: sample the parity bit, then move to DATA.
  - DATA: sample data bits into index 0..6, then move to STOP.
  - STOP: sample the stop bit and update outputs. Stop = 1 returns to IDLE; stop = 0 moves to WAIT_IDLE.
  - WAIT_IDLE: hold until rx_s == 1, then return to IDLE. This prevents a break or stuck-low line from retriggering.
- Sampling points: let e be the first cycle in IDLE with rx_s == 0, and H = CLKS_PER_BIT/2 (integer division).
  - Start check at e+H.
  - Parity at e+H+CLKS_PER_BIT.
  - Data bit k at e+H+(k+2)·CLKS_PER_BIT.
  - Stop bit at e+H+9·CLKS_PER_BIT.
- clk_count is 8 bits and resets to 0 at every sample point. Data bit index is 4 bits.
- Data is shifted into an internal register. data_out, parity_err and frame_err load together at the stop sample and hold until the next completed frame.
- A false start produces no update, and the outputs keep their previous values.
- A frame with an error still strobes out_valid; the error flags qualify that frame only.

## Timing
- Reset values: data_out = 0, out_valid = 0, parity_err = 0, frame_err = 0, busy = 0. The FSM resets to IDLE, counters to 0, and synchroniser flops to 1.
- Reset assertion mid-frame aborts immediately with no out_valid. After release the FSM waits in IDLE for the next rx_s falling level.
- out_valid is high for exactly the one cycle e+H+9·CLKS_PER_BIT+1. Latency from the rx start edge to out_valid is 3+H+9·CLKS_PER_BIT cycles.
- busy rises in cycle e+1. It falls in the same cycle that out_valid rises when stop = 1, or in the cycle after rx_s returns high when in WAIT_IDLE.
- Back-to-back frames, with stop immediately followed by the next start, must be received without loss. The FSM is in IDLE from the cycle after the stop sample, half a bit before the earliest next start edge.
- A glitch on rx shorter than H cycles during IDLE is a false start and must not disturb later frames.

## Test plan
- CLKS_PER_BIT=4, send 7'h55 with parity 0 and stop 1 -> one out_valid at the computed cycle with data_out=7'h55, parity_err=0, frame_err=0; busy drops with out_valid.
- Send 7'h01 with parity bit forced to 0 -> data_out=7'h01, parity_err=1, frame_err=0.
- Send 7'h7F with stop bit forced to 0, line held low 3 bit times, then released -> out_valid with frame_err=1; busy stays high until 2 cycles after rx returns high; no second frame is reported.
- Drive a 1-cycle low pulse on an idle rx -> no out_valid; data_out unchanged. Then send 7'h2A -> received correctly.
- Send 7'h12, 7'h6D, 7'h00 back-to-back from a `sender` instance with the same CLKS_PER_BIT -> three out_valid strobes carrying 7'h12, 7'h6D, 7'h00, all with error flags 0.
- Assert rst_n low while DATA is sampling bit 3 -> all outputs 0 and no out_valid. The next full frame 7'h33 is received correctly.
